// File: rtl/dcache_dm_if.sv
// dcache_dm_if: core-side and backing-memory-side signals of the direct-mapped
// data cache, grouped so the cache takes a single bus port.
//   slave  : the cache's view
//   master : the environment's view (core plus backing memory)
interface dcache_dm_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  addr, wdata, we, re, mem_rdata, mem_ready,
    output rdata, stall, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output addr, wdata, we, re, mem_rdata, mem_ready,
    input  rdata, stall, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, one-word-per-line, write-through /
// no-write-allocate data cache sitting between a core and a slow memory.
// Read hits return data combinationally with no stall. Read misses fill the
// line and forward memory data in the ready cycle. Writes always go to memory
// and update the line only when it already holds the address.
// Optional feature: define DCACHE_STATS_EN to add hit_count / miss_count.
//
// state | meaning
// IDLE  | serving hits, accepting new requests
// FILL  | read miss, waiting for mem_ready to install the line
// WRITE | write-through store, waiting for mem_ready
module dcache_dm #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8
) (
  input  logic              clk,
  input  logic              rst,
  dcache_dm_if.slave        bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [TAG_W-1:0]      tag_d  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];
  logic [DATA_WIDTH-1:0] data_d [SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic [1:0]            unused_addr_lsb;

  assign idx             = bus.addr[2 +: IDX_W];
  assign tag             = bus.addr[DATA_WIDTH-1 -: TAG_W];
  assign hit             = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_lsb = bus.addr[1:0];

  // Next state, line updates and all bus outputs.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    bus.rdata     = '0;
    bus.stall     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {bus.addr[DATA_WIDTH-1:2], 2'b00};
    bus.mem_wdata = bus.wdata;

    unique case (state_q)
      IDLE: begin
        if (bus.we) begin
          state_d   = WRITE;
          bus.stall = 1'b1;
        end else if (bus.re) begin
          if (hit) begin
            bus.rdata = data_q[idx];
          end else begin
            state_d   = FILL;
            bus.stall = 1'b1;
          end
        end
      end

      FILL: begin
        bus.mem_re = 1'b1;
        bus.stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          bus.rdata = bus.mem_rdata;
          state_d   = IDLE;
          // A reset edge aborts the fill: nothing gets installed.
          if (!rst) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = tag;
            data_d[idx]  = bus.mem_rdata;
          end
        end
      end

      WRITE: begin
        bus.mem_we = 1'b1;
        bus.stall  = !bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = IDLE;
          // No-write-allocate: only a line already holding this address changes.
          if (hit && !rst) begin
            data_d[idx] = bus.wdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and valid bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Line tags and data need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef DCACHE_STATS_EN
  logic        hit_ev;
  logic        miss_ev;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Only IDLE loads count: hits serviced and misses that start a fill.
  always_comb begin
    hit_ev       = (state_q == IDLE) && !bus.we && bus.re && hit;
    miss_ev      = (state_q == IDLE) && !bus.we && bus.re && !hit;
    hit_count_d  = hit_count_q + (hit_ev ? 32'd1 : 32'd0);
    miss_count_d = miss_count_q + (miss_ev ? 32'd1 : 32'd0);
  end

  // Statistics counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed bench for dcache_dm with a memory responder and an
// expected-read-data queue filled when each load is issued.
module tb_dcache_dm;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_dm_if #(.DATA_WIDTH(DW)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int          exp_hits;
  int          exp_misses;
`endif

  dcache_dm #(.DATA_WIDTH(DW), .SETS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic check_stats(input string name);
    check({name, " hit_count"}, hit_count, exp_hits);
    check({name, " miss_count"}, miss_count, exp_misses);
  endtask
`endif

  // One core transaction. exp_mem says whether memory must be used; the memory
  // answers with mem_ready in its (wait_n+1)-th active cycle.
  task automatic txn(input bit is_wr, input bit also_re, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] mdata, input int wait_n,
                     input bit exp_mem, input logic [31:0] exp_rd, input string name);
    int          stall_n = 0;
    int          re_n = 0;
    int          we_n = 0;
    int          mem_n = 0;
    int          bad_n = 0;
    int          budget = 0;
    bit          done = 0;
    logic [31:0] got = '0;
    logic [31:0] want;
    logic [31:0] seen_addr = '0;
    logic [31:0] seen_wdata = '0;

    @(posedge clk); #1;
    bus.we        = is_wr;
    bus.re        = !is_wr || also_re;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    if (!is_wr) exp_q.push_back(exp_rd);

    while (!done) begin
      @(negedge clk);
      if (bus.mem_re || bus.mem_we) begin
        if (bus.mem_re) re_n++;
        if (bus.mem_we) we_n++;
        if (bus.mem_re && bus.mem_we) bad_n++;
        if (mem_n == wait_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mdata;
          seen_addr     = bus.mem_addr;
          seen_wdata    = bus.mem_wdata;
        end
        mem_n++;
      end
      #1;
      if (bus.stall) begin
        stall_n++;
        if (bus.rdata !== '0) bad_n++;
      end else begin
        done = 1;
        got  = bus.rdata;
      end
      budget++;
      if (!done && budget >= 40) begin
        check({name, " timeout"}, 32'd0, 32'd1);
        done = 1;
      end
    end

    if (!is_wr) begin
      want = exp_q.pop_front();
      check({name, " rdata"}, got, want);
`ifdef DCACHE_STATS_EN
      if (exp_mem) exp_misses++;
      else         exp_hits++;
`endif
    end
    check({name, " stall_cycles"}, stall_n, exp_mem ? wait_n + 1 : 0);
    check({name, " mem_re_cycles"}, re_n, (exp_mem && !is_wr) ? wait_n + 1 : 0);
    check({name, " mem_we_cycles"}, we_n, (exp_mem && is_wr) ? wait_n + 1 : 0);
    check({name, " overlap_or_rdata_in_stall"}, bad_n, 0);
    if (exp_mem) begin
      check({name, " mem_addr"}, seen_addr, {a[31:2], 2'b00});
      if (is_wr) check({name, " mem_wdata"}, seen_wdata, wd);
    end

    @(posedge clk); #1;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check({name, " idle_ctrl"}, {29'd0, bus.stall, bus.mem_re, bus.mem_we}, 32'd0);
    check({name, " idle_rdata"}, bus.rdata, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stall", {31'd0, bus.stall}, 32'd0);
    check("reset rdata", bus.rdata, 32'd0);
    check("reset mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
`ifdef DCACHE_STATS_EN
    check_stats("reset");
`endif

    //  wr re  addr        wdata         mem data      wait mem  expected rdata
    txn(0, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF, "fill_100");
    txn(0, 0, 32'h100, 32'h0,        32'h0,        0, 0, 32'hDEADBEEF, "hit_100");
`ifdef DCACHE_STATS_EN
    check_stats("after_fill_hit");
`endif
    txn(1, 0, 32'h100, 32'h12345678, 32'h0,        2, 1, 32'h0,        "write_hit_100");
    txn(0, 0, 32'h100, 32'h0,        32'h0,        0, 0, 32'h12345678, "hit_100_new");
    txn(0, 0, 32'h120, 32'h0,        32'hCAFEF00D, 1, 1, 32'hCAFEF00D, "conflict_120");
    txn(0, 0, 32'h120, 32'h0,        32'h0,        0, 0, 32'hCAFEF00D, "hit_120");
    txn(0, 0, 32'h100, 32'h0,        32'h12345678, 0, 1, 32'h12345678, "refill_100");
    txn(1, 0, 32'h200, 32'hA5A5A5A5, 32'h0,        0, 1, 32'h0,        "write_miss_200");
    txn(0, 0, 32'h100, 32'h0,        32'h0,        0, 0, 32'h12345678, "still_100");
    txn(0, 0, 32'h200, 32'h0,        32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, "no_alloc_200");
    txn(0, 0, 32'h104, 32'h0,        32'h0BADC0DE, 3, 1, 32'h0BADC0DE, "fill_104_slow");
    txn(0, 0, 32'h106, 32'h0,        32'h0,        0, 0, 32'h0BADC0DE, "hit_104_lsb");
    txn(0, 0, 32'h11C, 32'h0,        32'h77778888, 0, 1, 32'h77778888, "fill_11c");
    txn(1, 1, 32'h104, 32'h44332211, 32'h0,        1, 1, 32'h0,        "we_over_re_104");
    txn(0, 0, 32'h104, 32'h0,        32'h0,        0, 0, 32'h44332211, "hit_104_new");
    txn(0, 0, 32'h11C, 32'h0,        32'h0,        0, 0, 32'h77778888, "hit_11c");
`ifdef DCACHE_STATS_EN
    check_stats("mid_run");
`endif

    // Reset while a fill is outstanding, with mem_ready arriving during reset.
    @(posedge clk); #1;
    bus.re   = 1'b1;
    bus.addr = 32'h300;
    @(negedge clk);
    check("rst_fill idle_miss stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_fill in_fill mem_re", {31'd0, bus.mem_re}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h99999999;
    @(negedge clk);
    check("rst_fill after_rst mem_re", {31'd0, bus.mem_re}, 32'd0);
    check("rst_fill after_rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.re        = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("post_rst stall", {31'd0, bus.stall}, 32'd0);
    check("post_rst rdata", bus.rdata, 32'd0);
`ifdef DCACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
    check_stats("post_rst");
`endif
    txn(0, 0, 32'h300, 32'h0, 32'h13572468, 0, 1, 32'h13572468, "post_rst_miss_300");
    txn(0, 0, 32'h104, 32'h0, 32'h44332211, 0, 1, 32'h44332211, "post_rst_miss_104");
    txn(0, 0, 32'h300, 32'h0, 32'h0,        0, 0, 32'h13572468, "post_rst_hit_300");
`ifdef DCACHE_STATS_EN
    check_stats("final");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dcache_dm.md
DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of the data word and of both address buses.
REQ-002 Parameter SETS, 8, number of direct-mapped lines (power of two, >=2); one word per line.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 addr  input  DATA_WIDTH  core byte address (ALU result); addr[1:0] ignored (word access only).
REQ-006 wdata  input  DATA_WIDTH  core store data.
REQ-007 we  input  1  core store request.
REQ-008 re  input  1  core load request.
REQ-009 rdata  output  DATA_WIDTH  load data to core (feeds the result mux).
REQ-010 stall  output  1  core shall hold PC and all architectural writes while high.
REQ-011 mem_addr, mem_wdata  output  DATA_WIDTH each  backing-memory address and store data.
REQ-012 mem_re, mem_we  output  1 each  backing-memory read and write strobes.
REQ-013 mem_rdata  input  DATA_WIDTH  backing-memory read data, valid when mem_ready=1.
REQ-014 mem_ready  input  1  one-cycle pulse: current memory transaction completes this cycle.

Function
REQ-015 Address split: index = addr[2+log2(SETS)-1:2], tag = addr[DATA_WIDTH-1:2+log2(SETS)]; hit = valid[index] && tag match.
REQ-016 FSM states IDLE, FILL, WRITE; IDLE->FILL on re && !we && !hit; IDLE->WRITE on we; FILL->IDLE and WRITE->IDLE on mem_ready; otherwise hold state.
REQ-017 we has priority over re when both are high in IDLE.
REQ-018 Read hit in IDLE: rdata = line data combinationally, stall=0, zero added cycles.
REQ-019 stall = 1 in IDLE on read miss or on we; stall = 1 in FILL/WRITE except in the mem_ready cycle, where stall = 0.
REQ-020 FILL: mem_re=1, mem_addr = {addr[DATA_WIDTH-1:2],2'b00} held stable; on mem_ready, rdata = mem_rdata (forwarded the same cycle), line data, tag and valid written at that edge.
REQ-021 WRITE (write-through, no-write-allocate): mem_we=1, mem_addr/mem_wdata from addr/wdata held stable; on mem_ready, if hit the line data is updated to wdata at that edge, if miss the line is unchanged.
REQ-022 mem_re and mem_we are never high together and are 0 in IDLE.
REQ-023 rdata = 0 whenever neither a hit in IDLE nor a FILL completion applies.
REQ-024 Miss with mem_ready on first FILL cycle costs exactly 1 stall cycle; each extra memory wait cycle adds 1.
REQ-025 Core inputs are stable while stall=1; the block need not tolerate changes mid-transaction.

Reset
REQ-026 rst=1 at an edge: state <= IDLE, all valid bits <= 0; line data/tags need not reset.
REQ-027 Reset mid-FILL or mid-WRITE aborts the transaction: no line update, mem_re/mem_we = 0 from the cycle after the reset edge; a mem_ready arriving during or after reset is ignored.
REQ-028 Outputs after reset: stall=0 (absent a request), rdata=0, mem_re=0, mem_we=0.

Configuration
REQ-029 Macro DCACHE_STATS_EN: when defined, adds outputs hit_count and miss_count (32 bits each, reset to 0, wrap at 2^32); hit_count +1 per IDLE read hit, miss_count +1 per IDLE->FILL transition; writes not counted. When undefined, ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-030 After reset, re=1, addr=0x100, memory returns 0xDEADBEEF with mem_ready on first FILL cycle -> stall high 1 cycle, rdata=0xDEADBEEF in ready cycle; repeat read -> hit, stall=0, rdata=0xDEADBEEF, no mem_re.
REQ-031 we=1, addr=0x100, wdata=0x12345678 after line filled, mem_ready after 3 cycles -> mem_we high 3 cycles, stall low in ready cycle, next read of 0x100 hits returning 0x12345678.
REQ-032 Conflict: fill 0x100, then read 0x120 (same index, SETS=8) -> miss and refill; read 0x100 again -> miss.
REQ-033 Write miss to 0x200 then read 0x200 -> read misses (no allocate), mem_re issued.
REQ-034 rst asserted during FILL with mem_ready next cycle -> no line installed, valid cleared, following read of same address misses.
REQ-035 With DCACHE_STATS_EN: sequence of REQ-030 -> hit_count=1, miss_count=1; counters 0 after reset.
